// File: rtl/subservient_wb_arb_pkg.sv
// rtl/subservient_wb_arb_pkg.sv - state encoding and master indices for the SRAM Wishbone arbiter
package subservient_wb_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GNT_I = 2'd1;
   localparam logic [1:0] ST_GNT_D = 2'd2;
   localparam logic [1:0] ST_GNT_X = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      GNT_I = ST_GNT_I,
      GNT_D = ST_GNT_D,
      GNT_X = ST_GNT_X
   } arb_state_e;

   localparam logic [1:0] M_IBUS = 2'd0;
   localparam logic [1:0] M_DBUS = 2'd1;
   localparam logic [1:0] M_DBG  = 2'd2;

endpackage

// File: rtl/subservient_wb_arb.sv
// rtl/subservient_wb_arb.sv - ibus/dbus(/debug) arbiter onto the shared SRAM Wishbone port
// Optional debug master enabled by SUBSERVIENT_ARB_DBG_EN.
module subservient_wb_arb
   import subservient_wb_arb_pkg::*;
#(
   parameter int depth = 256,
   parameter int aw    = $clog2(depth)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic [aw-3:0] i_ibus_adr,
   input  logic          i_ibus_cyc,
   output logic [31:0]   o_ibus_rdt,
   output logic          o_ibus_ack,
   input  logic [aw-3:0] i_dbus_adr,
   input  logic [31:0]   i_dbus_dat,
   input  logic [3:0]    i_dbus_sel,
   input  logic          i_dbus_we,
   input  logic          i_dbus_cyc,
   output logic [31:0]   o_dbus_rdt,
   output logic          o_dbus_ack,
`ifdef SUBSERVIENT_ARB_DBG_EN
   input  logic [aw-3:0] i_dbg_adr,
   input  logic [31:0]   i_dbg_dat,
   input  logic [3:0]    i_dbg_sel,
   input  logic          i_dbg_we,
   input  logic          i_dbg_cyc,
   output logic [31:0]   o_dbg_rdt,
   output logic          o_dbg_ack,
`endif
   output logic [aw-3:0] o_wb_adr,
   output logic [31:0]   o_wb_dat,
   output logic [3:0]    o_wb_sel,
   output logic          o_wb_we,
   output logic          o_wb_stb,
   input  logic [31:0]   i_wb_rdt,
   input  logic          i_wb_ack
);

   arb_state_e state_q, state_d;
   logic [1:0] rr_last_q, rr_last_d;
   logic       granted;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         rr_last_q <= M_DBUS;
      end else begin
         state_q   <= state_d;
         rr_last_q <= rr_last_d;
      end
   end

   // Grant is only re-evaluated from IDLE, so every ack is followed by a one-cycle bubble.
   always_comb begin
      state_d   = state_q;
      rr_last_d = rr_last_q;
      case (state_q)
         IDLE: begin
`ifdef SUBSERVIENT_ARB_DBG_EN
            if (i_dbg_cyc) begin
               state_d = GNT_X;
            end else
`endif
            if (i_ibus_cyc && (!i_dbus_cyc || rr_last_q == M_DBUS)) begin
               state_d   = GNT_I;
               rr_last_d = M_IBUS;
            end else if (i_dbus_cyc) begin
               state_d   = GNT_D;
               rr_last_d = M_DBUS;
            end
         end
         default: begin
            if (i_wb_ack) state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      o_wb_adr = '0;
      o_wb_dat = '0;
      o_wb_sel = '0;
      o_wb_we  = 1'b0;
      granted  = 1'b0;
      case (state_q)
         GNT_I: begin
            granted  = 1'b1;
            o_wb_adr = i_ibus_adr;
            o_wb_sel = 4'hf;
         end
         GNT_D: begin
            granted  = 1'b1;
            o_wb_adr = i_dbus_adr;
            o_wb_dat = i_dbus_dat;
            o_wb_sel = i_dbus_sel;
            o_wb_we  = i_dbus_we;
         end
`ifdef SUBSERVIENT_ARB_DBG_EN
         GNT_X: begin
            granted  = 1'b1;
            o_wb_adr = i_dbg_adr;
            o_wb_dat = i_dbg_dat;
            o_wb_sel = i_dbg_sel;
            o_wb_we  = i_dbg_we;
         end
`endif
         default: ;
      endcase
   end

   assign o_wb_stb = granted & ~i_wb_ack;

   // Read data is zeroed whenever its ack is low so the buses can be OR-merged downstream.
   assign o_ibus_ack = (state_q == GNT_I) & i_wb_ack;
   assign o_ibus_rdt = o_ibus_ack ? i_wb_rdt : 32'd0;
   assign o_dbus_ack = (state_q == GNT_D) & i_wb_ack;
   assign o_dbus_rdt = o_dbus_ack ? i_wb_rdt : 32'd0;
`ifdef SUBSERVIENT_ARB_DBG_EN
   assign o_dbg_ack  = (state_q == GNT_X) & i_wb_ack;
   assign o_dbg_rdt  = o_dbg_ack ? i_wb_rdt : 32'd0;
`endif

endmodule

// File: tb/tb_subservient_wb_arb.sv
// tb/tb_subservient_wb_arb.sv - randomized, model-checked bench for subservient_wb_arb
module tb_subservient_wb_arb;

   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int NONE  = -1;
   localparam int MI    = 0;
   localparam int MD    = 1;
   localparam int MX    = 2;
`ifdef SUBSERVIENT_ARB_DBG_EN
   localparam int NM = 3;
`else
   localparam int NM = 2;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic [AW-3:0] ibus_adr, dbus_adr, dbg_adr, wb_adr;
   logic          ibus_cyc, dbus_cyc, dbg_cyc, ibus_ack, dbus_ack, dbg_ack;
   logic [31:0]   ibus_rdt, dbus_rdt, dbg_rdt, dbus_dat, dbg_dat, wb_dat, wb_rdt;
   logic [3:0]    dbus_sel, dbg_sel, wb_sel;
   logic          dbus_we, dbg_we, wb_we, wb_stb, wb_ack;

   subservient_wb_arb #(.depth(DEPTH)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_ibus_adr(ibus_adr), .i_ibus_cyc(ibus_cyc), .o_ibus_rdt(ibus_rdt), .o_ibus_ack(ibus_ack),
      .i_dbus_adr(dbus_adr), .i_dbus_dat(dbus_dat), .i_dbus_sel(dbus_sel), .i_dbus_we(dbus_we),
      .i_dbus_cyc(dbus_cyc), .o_dbus_rdt(dbus_rdt), .o_dbus_ack(dbus_ack),
`ifdef SUBSERVIENT_ARB_DBG_EN
      .i_dbg_adr(dbg_adr), .i_dbg_dat(dbg_dat), .i_dbg_sel(dbg_sel), .i_dbg_we(dbg_we),
      .i_dbg_cyc(dbg_cyc), .o_dbg_rdt(dbg_rdt), .o_dbg_ack(dbg_ack),
`endif
      .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_sel(wb_sel), .o_wb_we(wb_we),
      .o_wb_stb(wb_stb), .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack)
   );

`ifndef SUBSERVIENT_ARB_DBG_EN
   assign dbg_ack = 1'b0;
   assign dbg_rdt = 32'd0;
`endif

   int n_chk = 0;
   int n_fail = 0;

   // Bench-side masters: a pending request holds cyc and its fields until acked.
   bit            pend[3];
   logic [AW-3:0] m_adr[3];
   logic [31:0]   m_dat[3];
   logic [3:0]    m_sel[3];
   logic          m_we[3];
   int            req_pct[3];

   // Reference model: who owns the SRAM port, and how long the SRAM takes.
   int owner = NONE;
   int rr_last = MD;
   int cnt, cur_lat;
   int lat_fixed, spur_pct;
   bit rand_rdt;
   logic [31:0] rdt_val;
   bit rst_req, chk_en;
   int cyc_n = 0;

   int          ack_who[$];
   int          ack_cyc[$];
   logic [31:0] ack_rdt[$];
   logic        ack_stb[$];
   int          n_ack[3];
   logic        last_stb, last_iack, last_dack;
   logic [31:0] last_irdt, last_drdt;
   bit          seen_stb;
   logic        fs_we;
   logic [3:0]  fs_sel;
   logic [31:0] fs_dat;
   logic [AW-3:0] fs_adr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic log_ack(input int who, input logic [31:0] rdt);
      ack_who.push_back(who);
      ack_cyc.push_back(cyc_n);
      ack_rdt.push_back(rdt);
      ack_stb.push_back(wb_stb);
      n_ack[who]++;
   endtask

   task automatic cycle();
      bit e_ack;
      logic [31:0] racts[3];
      logic        aacts[3];
      @(negedge clk);
      rst = rst_req;
      for (int m = 0; m < NM; m++) begin
         if (!pend[m] && $urandom_range(99) < req_pct[m]) begin
            pend[m]  = 1'b1;
            m_adr[m] = (AW-2)'($urandom_range(2**(AW-2)-1));
            m_dat[m] = $urandom;
            m_sel[m] = 4'($urandom_range(15));
            m_we[m]  = (m == MI) ? 1'b0 : 1'($urandom_range(1));
         end
      end
      ibus_cyc = pend[MI]; ibus_adr = m_adr[MI];
      dbus_cyc = pend[MD]; dbus_adr = m_adr[MD]; dbus_dat = m_dat[MD];
      dbus_sel = m_sel[MD]; dbus_we = m_we[MD];
      dbg_cyc  = pend[MX]; dbg_adr = m_adr[MX]; dbg_dat = m_dat[MX];
      dbg_sel  = m_sel[MX]; dbg_we = m_we[MX];
      if (owner != NONE) wb_ack = (cnt == cur_lat);
      else               wb_ack = ($urandom_range(99) < spur_pct);
      wb_rdt = rand_rdt ? $urandom : rdt_val;
      #1;
      last_stb = wb_stb; last_iack = ibus_ack; last_dack = dbus_ack;
      last_irdt = ibus_rdt; last_drdt = dbus_rdt;
      if (wb_stb && !seen_stb) begin
         seen_stb = 1'b1; fs_we = wb_we; fs_sel = wb_sel; fs_dat = wb_dat; fs_adr = wb_adr;
      end
      if (chk_en) begin
         check("wb_stb", 32'(wb_stb), 32'(owner != NONE && !wb_ack));
         if (owner != NONE) begin
            check("wb_adr", 32'(wb_adr), 32'(m_adr[owner]));
            check("wb_we", 32'(wb_we), 32'(m_we[owner]));
            check("wb_sel", 32'(wb_sel), (owner == MI) ? 32'hf : 32'(m_sel[owner]));
            if (owner != MI) check("wb_dat", wb_dat, m_dat[owner]);
         end
         aacts[MI] = ibus_ack; aacts[MD] = dbus_ack; aacts[MX] = dbg_ack;
         racts[MI] = ibus_rdt; racts[MD] = dbus_rdt; racts[MX] = dbg_rdt;
         for (int m = 0; m < NM; m++) begin
            e_ack = (owner == m) && wb_ack;
            check($sformatf("ack%0d", m), 32'(aacts[m]), 32'(e_ack));
            check($sformatf("rdt%0d", m), racts[m], e_ack ? wb_rdt : 32'd0);
         end
      end
      if (ibus_ack) log_ack(MI, ibus_rdt);
      if (dbus_ack) log_ack(MD, dbus_rdt);
      if (dbg_ack)  log_ack(MX, dbg_rdt);
      if (owner != NONE && wb_ack) pend[owner] = 1'b0;
      if (rst) begin
         owner = NONE; rr_last = MD;
      end else if (owner == NONE) begin
         if (pend[MX])                  owner = MX;
         else if (pend[MI] && pend[MD]) owner = (rr_last == MD) ? MI : MD;
         else if (pend[MI])             owner = MI;
         else if (pend[MD])             owner = MD;
         if (owner == MI || owner == MD) rr_last = owner;
         cnt = 0;
         cur_lat = (lat_fixed > 0) ? lat_fixed : $urandom_range(6, 1);
      end else if (wb_ack) begin
         owner = NONE;
      end else begin
         cnt++;
      end
      cyc_n++;
   endtask

   task automatic do_reset();
      for (int m = 0; m < 3; m++) begin
         pend[m] = 1'b0; req_pct[m] = 0; n_ack[m] = 0;
      end
      rst_req = 1'b1;
      cycle();
      chk_en = 1'b1;
      cycle();
      rst_req = 1'b0;
      ack_who.delete(); ack_cyc.delete(); ack_rdt.delete(); ack_stb.delete();
      seen_stb = 1'b0;
   endtask

   task automatic run_until(input int n, input int budget);
      int b = budget;
      while (ack_who.size() < n && b > 0) begin
         cycle();
         b--;
      end
      check("ack_count_within_budget", ack_who.size(), n);
   endtask

   initial begin
      int start;
      rst = 1'b1; wb_ack = 1'b0; wb_rdt = '0;
      chk_en = 1'b0; spur_pct = 0; lat_fixed = 5; rand_rdt = 1'b0; rdt_val = 32'h0;
      do_reset();
      check("reset_stb", 32'(last_stb), 32'd0);
      check("reset_iack", 32'(last_iack), 32'd0);
      check("reset_dack", 32'(last_dack), 32'd0);

      // Single ibus fetch, SRAM latency 5.
      rdt_val = 32'h0000_0013;
      pend[MI] = 1'b1; m_adr[MI] = 6'h10; m_we[MI] = 1'b0; m_sel[MI] = 4'hf;
      start = cyc_n;
      run_until(1, 30);
      if (ack_who.size() >= 1) begin
         check("t1_who", ack_who[0], MI);
         check("t1_latency", ack_cyc[0] - start, 6);
         check("t1_rdt", ack_rdt[0], 32'h0000_0013);
         check("t1_stb_in_ack", 32'(ack_stb[0]), 32'd0);
         check("t1_adr", 32'(fs_adr), 32'h10);
      end
      check("t1_no_dbus_ack", n_ack[MD], 0);

      // Both held from reset: I, D, I, D with a bubble between grants.
      do_reset();
      req_pct[MI] = 100; req_pct[MD] = 100;
      run_until(4, 80);
      if (ack_who.size() >= 4) begin
         check("t2_g0", ack_who[0], MI);
         check("t2_g1", ack_who[1], MD);
         check("t2_g2", ack_who[2], MI);
         check("t2_g3", ack_who[3], MD);
         for (int k = 1; k < 4; k++)
            check("t2_spacing", ack_cyc[k] - ack_cyc[k-1], 7);
      end

      // dbus write fields pass through.
      do_reset();
      pend[MD] = 1'b1; m_adr[MD] = 6'h04; m_dat[MD] = 32'hA5A5_A5A5;
      m_sel[MD] = 4'b0011; m_we[MD] = 1'b1;
      run_until(1, 30);
      check("t3_we", 32'(fs_we), 32'd1);
      check("t3_sel", 32'(fs_sel), 32'h3);
      check("t3_dat", fs_dat, 32'hA5A5_A5A5);
      check("t3_adr", 32'(fs_adr), 32'h04);
      if (ack_who.size() >= 1) check("t3_who", ack_who[0], MD);
      check("t3_no_ibus_ack", n_ack[MI], 0);

`ifdef SUBSERVIENT_ARB_DBG_EN
      // Debug wins first, then round-robin.
      do_reset();
      for (int m = 0; m < 3; m++) begin
         pend[m] = 1'b1; m_adr[m] = 6'(m + 1); m_dat[m] = 32'(m); m_sel[m] = 4'hf;
         m_we[m] = 1'b0;
      end
      run_until(3, 60);
      if (ack_who.size() >= 3) begin
         check("t4_g0", ack_who[0], MX);
         check("t4_g1", ack_who[1], MI);
         check("t4_g2", ack_who[2], MD);
      end
`endif

      // Reset during a dbus grant.
      do_reset();
      pend[MD] = 1'b1; m_adr[MD] = 6'h08; m_we[MD] = 1'b0; m_sel[MD] = 4'hf; m_dat[MD] = 32'h1;
      cycle(); cycle(); cycle();
      check("t5_granted", 32'(last_stb), 32'd1);
      rst_req = 1'b1;
      cycle();
      rst_req = 1'b0;
      pend[MD] = 1'b0;
      cycle();
      check("t5_stb_after_rst", 32'(last_stb), 32'd0);
      check("t5_iack", 32'(last_iack), 32'd0);
      check("t5_dack", 32'(last_dack), 32'd0);
      check("t5_no_acks", ack_who.size(), 0);

      // Spurious SRAM ack while idle.
      do_reset();
      spur_pct = 100; rand_rdt = 1'b0; rdt_val = 32'hDEAD_BEEF;
      cycle(); cycle();
      check("t6_iack", 32'(last_iack), 32'd0);
      check("t6_dack", 32'(last_dack), 32'd0);
      check("t6_irdt", last_irdt, 32'd0);
      check("t6_drdt", last_drdt, 32'd0);

      // Randomized traffic with random SRAM latency, spurious acks and resets.
      do_reset();
      req_pct[MI] = 30; req_pct[MD] = 30; req_pct[MX] = 10;
      spur_pct = 20; lat_fixed = 0; rand_rdt = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rst_req = ($urandom_range(199) == 0);
         cycle();
      end
      rst_req = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/subservient_wb_arb.md
Name: subservient_wb_arb

Overview:
- Wishbone arbiter in front of the shared RF/I-D SRAM controller.
- Merges up to three masters onto the single 32-bit byte-serialised SRAM Wishbone port: SERV instruction bus, SERV data bus, and an optional debug/loader bus.
- Grants one master per transaction, routes ack and read data back to that master only, and holds the grant until the SRAM side acks.

Parameters:
depth, 256, SRAM depth in bytes; must match the downstream SRAM controller
aw, $clog2(depth), byte address width; word address is [aw-1:2]

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_ibus_adr  in  aw-2  instruction fetch word address
i_ibus_cyc  in  1  instruction fetch request
o_ibus_rdt  out  32  instruction read data
o_ibus_ack  out  1  instruction ack
i_dbus_adr  in  aw-2  data word address
i_dbus_dat  in  32  data write data
i_dbus_sel  in  4  data byte enables
i_dbus_we  in  1  data write enable
i_dbus_cyc  in  1  data request
o_dbus_rdt  out  32  data read data
o_dbus_ack  out  1  data ack
i_dbg_adr  in  aw-2  debug word address (only with SUBSERVIENT_ARB_DBG_EN)
i_dbg_dat  in  32  debug write data (only with SUBSERVIENT_ARB_DBG_EN)
i_dbg_sel  in  4  debug byte enables (only with SUBSERVIENT_ARB_DBG_EN)
i_dbg_we  in  1  debug write enable (only with SUBSERVIENT_ARB_DBG_EN)
i_dbg_cyc  in  1  debug request (only with SUBSERVIENT_ARB_DBG_EN)
o_dbg_rdt  out  32  debug read data (only with SUBSERVIENT_ARB_DBG_EN)
o_dbg_ack  out  1  debug ack (only with SUBSERVIENT_ARB_DBG_EN)
o_wb_adr  out  aw-2  to SRAM controller, word address
o_wb_dat  out  32  to SRAM controller, write data
o_wb_sel  out  4  to SRAM controller, byte enables
o_wb_we  out  1  to SRAM controller, write enable
o_wb_stb  out  1  to SRAM controller, strobe
i_wb_rdt  in  32  from SRAM controller, read data
i_wb_ack  in  1  from SRAM controller, ack

Behaviour:
- Clock and reset: single clock i_clk; i_rst is synchronous, active-high. Reset: state IDLE, rr_last=dbus (so ibus wins the first tie), all acks 0, o_wb_stb 0.
- States:
  - IDLE: no grant; o_wb_stb=0.
  - GNT_I, GNT_D, GNT_X: grant held to ibus, dbus or debug respectively.
- IDLE transitions, evaluated on registered state:
  - dbg_cyc goes to GNT_X (highest priority).
  - Otherwise, if only one of ibus_cyc/dbus_cyc is set, grant it.
  - If both are set, grant the one not equal to rr_last; update rr_last on each ibus/dbus grant.
- Registered grant: grant takes effect the cycle after IDLE sees the request. Minimum latency from cyc to ack = 1 + SRAM latency, where SRAM latency is 5 cycles with no RF write stall.
- While granted:
  - o_wb_adr/dat/sel/we mux from the granted master; ibus forces we=0 and sel=4'hf.
  - o_wb_stb = granted & !i_wb_ack.
- On i_wb_ack:
  - The granted master's ack goes high combinationally for exactly that cycle; its rdt = i_wb_rdt. Non-granted acks stay 0.
  - Next state = IDLE, giving a mandatory one-cycle bubble so the master can drop cyc.
- Every rdt output is gated to 0 when its ack is low, so OR-reduction elsewhere is safe.
- Master dropping cyc mid-grant: not permitted (SERV never does). The arbiter keeps the grant until ack so the SRAM byte counter stays aligned.
- i_wb_ack in IDLE: ignored, no master acked.
- Reset mid-transaction: state returns to IDLE and no ack is issued. Top level resets the SRAM controller on the same i_rst.

Optional Feature:
- SUBSERVIENT_ARB_DBG_EN defined: debug port present; GNT_X is reachable and debug has top priority.
- Undefined: debug ports are absent, GNT_X is removed, and arbitration is ibus/dbus round-robin only.

Decomposition:
- Shared package: state encoding localparams (IDLE, GNT_I, GNT_D, GNT_X) and master index constants.
- No sub-module: the output mux is inline; a separate arbiter module is unnecessary at this size.

Test Plan:
- Reset, then ibus_cyc with adr=0x10 and SRAM acking rdt=0x00000013 after 5 cycles -> o_ibus_ack one cycle with rdt 0x00000013; o_dbus_ack stays 0; stb drops in the ack cycle.
- ibus_cyc and dbus_cyc both held after reset -> grants alternate I, D, I, D, with exactly one IDLE cycle between grants.
- dbus write adr=0x04, dat=0xA5A5A5A5, sel=4'b0011 -> o_wb_we=1, o_wb_sel=0011, o_wb_dat matches; ack returns to dbus only.
- SUBSERVIENT_ARB_DBG_EN, with dbg, ibus and dbus all requesting from IDLE -> GNT_X first, then round-robin I/D.
- i_rst asserted during GNT_D -> next cycle IDLE, o_wb_stb=0, no ack to any master.
- Spurious i_wb_ack in IDLE -> no master ack, all rdt outputs 0.
